// File: rtl/iomem_gpio_irq_pkg.sv
// Shared definitions for the iomem GPIO peripheral.
//   MAX_PINS     widest supported pin count (one bus word)
//   word_t       one iomem data word
//   strb_t       iomem byte write strobes
//   GPIO_*       register byte offsets within the block
//   strb_mask()  expands byte strobes into a per-bit write mask
package gpio_pkg;

    localparam int unsigned MAX_PINS = 32;

    typedef logic [MAX_PINS-1:0] word_t;
    typedef logic [3:0]          strb_t;

    localparam logic [7:0] GPIO_OUT     = 8'h00;
    localparam logic [7:0] GPIO_OE      = 8'h04;
    localparam logic [7:0] GPIO_IN      = 8'h08;
    localparam logic [7:0] GPIO_RISE_EN = 8'h0C;
    localparam logic [7:0] GPIO_FALL_EN = 8'h10;
    localparam logic [7:0] GPIO_PENDING = 8'h14;
    localparam logic [7:0] GPIO_OUT_SET = 8'h18;
    localparam logic [7:0] GPIO_OUT_CLR = 8'h1C;

    function automatic word_t strb_mask(input strb_t strb);
        word_t m;
        m = '0;
        for (int unsigned k = 0; k < 4; k++) begin
            m[k*8 +: 8] = {8{strb[k]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/iomem_gpio_irq_if.sv
// picosoc iomem bus bundle.
//   iomem_valid  request from master
//   iomem_ready  one-cycle acknowledge from slave
//   iomem_wstrb  byte write strobes (0 = read)
//   iomem_addr   byte address
//   iomem_wdata  write data
//   iomem_rdata  read data, valid while iomem_ready is high
interface iomem_gpio_irq_if;
    import gpio_pkg::*;

    logic  iomem_valid;
    logic  iomem_ready;
    strb_t iomem_wstrb;
    word_t iomem_addr;
    word_t iomem_wdata;
    word_t iomem_rdata;

    modport master (
        output iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata,
        input  iomem_ready, iomem_rdata
    );

    modport slave (
        input  iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata,
        output iomem_ready, iomem_rdata
    );

endinterface

// File: rtl/iomem_gpio_irq_sync_edge.sv
// Single-pin input synchroniser with edge detection.
//   clk, reset  system clock, synchronous active-high reset
//   pin         asynchronous pad input
//   level       synchronised level (SYNC_STAGES cycles behind pin)
//   rise, fall  one-cycle pulses when level differs from its previous value
module gpio_sync_edge #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic pin,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pin};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level = sync_q[SYNC_STAGES-1];
    assign rise  = level & ~prev_q;
    assign fall  = ~level & prev_q;

endmodule

// File: rtl/iomem_gpio_irq.sv
// GPIO peripheral on the picosoc iomem bus.
//   clk, reset   system clock, synchronous active-high reset
//   iomem        iomem bus, slave side; block selected by iomem_addr[31:24]
//   gpio_in      asynchronous pad inputs
//   gpio_out     output data register
//   gpio_oe      output enable per pin (1 = drive)
//   irq          level interrupt, OR of all pending bits
module iomem_gpio_irq
    import gpio_pkg::*;
#(
    parameter int unsigned NUM_PINS    = 32,
    parameter logic [7:0]  BASE_ADDR   = 8'h03,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                reset,
    iomem_gpio_irq_if.slave     iomem,
    input  logic [NUM_PINS-1:0] gpio_in,
    output logic [NUM_PINS-1:0] gpio_out,
    output logic [NUM_PINS-1:0] gpio_oe,
    output logic                irq
);

    logic [NUM_PINS-1:0] out_q, oe_q, rise_en_q, fall_en_q, pend_q;
    logic [NUM_PINS-1:0] in_lvl, in_rise, in_fall, pend_set;
    logic [NUM_PINS-1:0] wsel, wbits;
    logic                ready_q;
    word_t               rdata_q, rd_mux, wmask;
    logic                hit;
    logic [7:0]          offset;
    logic                unused_bits;

    // A request is taken only when ready is low, so a master holding valid
    // through the acknowledge cycle is not served twice.
    assign hit    = iomem.iomem_valid && !ready_q
                    && (iomem.iomem_addr[31:24] == BASE_ADDR);
    assign offset = {iomem.iomem_addr[7:2], 2'b00};

    // Byte strobes gate every writable register, including W1C/SET/CLR;
    // a read (wstrb = 0) therefore writes nothing.
    assign wmask = strb_mask(iomem.iomem_wstrb);
    assign wsel  = wmask[NUM_PINS-1:0];
    assign wbits = iomem.iomem_wdata[NUM_PINS-1:0] & wsel;

    assign unused_bits = ^{iomem.iomem_addr[23:8], iomem.iomem_addr[1:0],
                           iomem.iomem_wdata, wmask};

    for (genvar i = 0; i < NUM_PINS; i++) begin : g_pin
        gpio_sync_edge #(
            .SYNC_STAGES(SYNC_STAGES)
        ) u_sync (
            .clk   (clk),
            .reset (reset),
            .pin   (gpio_in[i]),
            .level (in_lvl[i]),
            .rise  (in_rise[i]),
            .fall  (in_fall[i])
        );
    end

    assign pend_set = (in_rise & rise_en_q) | (in_fall & fall_en_q);

    always_comb begin
        rd_mux = '0;
        case (offset)
            GPIO_OUT:     rd_mux = word_t'(out_q);
            GPIO_OE:      rd_mux = word_t'(oe_q);
            GPIO_IN:      rd_mux = word_t'(in_lvl);
            GPIO_RISE_EN: rd_mux = word_t'(rise_en_q);
            GPIO_FALL_EN: rd_mux = word_t'(fall_en_q);
            GPIO_PENDING: rd_mux = word_t'(pend_q);
            default:      rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ready_q   <= 1'b0;
            rdata_q   <= '0;
            out_q     <= '0;
            oe_q      <= '0;
            rise_en_q <= '0;
            fall_en_q <= '0;
            pend_q    <= '0;
        end else begin
            ready_q <= hit;
            if (hit) begin
                rdata_q <= rd_mux;
            end

            if (hit && offset == GPIO_OUT) begin
                out_q <= (out_q & ~wsel) | wbits;
            end else if (hit && offset == GPIO_OUT_SET) begin
                out_q <= out_q | wbits;
            end else if (hit && offset == GPIO_OUT_CLR) begin
                out_q <= out_q & ~wbits;
            end

            if (hit && offset == GPIO_OE) begin
                oe_q <= (oe_q & ~wsel) | wbits;
            end
            if (hit && offset == GPIO_RISE_EN) begin
                rise_en_q <= (rise_en_q & ~wsel) | wbits;
            end
            if (hit && offset == GPIO_FALL_EN) begin
                fall_en_q <= (fall_en_q & ~wsel) | wbits;
            end

            // Clear is applied before set so a new edge wins over a W1C.
            if (hit && offset == GPIO_PENDING) begin
                pend_q <= (pend_q & ~wbits) | pend_set;
            end else begin
                pend_q <= pend_q | pend_set;
            end
        end
    end

    assign iomem.iomem_ready = ready_q;
    assign iomem.iomem_rdata = rdata_q;
    assign gpio_out          = out_q;
    assign gpio_oe           = oe_q;
    assign irq               = |pend_q;

endmodule
